instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 71 +++++++
 tb/tb_instruction_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, boot/run/halt FSM and fetch-stage pipeline register
// with redirect/stall handling and optional in-fetch j/jal target resolution.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          PREDECODE_J = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);
    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_j;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign halted    = state == HALTED;
    // opcodes 000010 (j) and 000011 (jal) share the upper five bits
    assign is_j      = (PREDECODE_J != 0) && (imem_instr[31:27] == 5'b00001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= 32'd0;
            if_pc        <= 32'd0;
            if_pc_plus4  <= 32'd0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'd0;
        end else if (state == BOOT) begin
            state    <= RUN;
            if_valid <= 1'b0;
        end else if (state == RUN) begin
            if (redirect_valid) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                if_valid <= 1'b0;
                if (|redirect_pc[1:0]) misalign_err <= 1'b1;
            end else if (halt_req) begin
                if_valid <= 1'b0;
                state    <= HALTED;
            end else if (!stall) begin
                if_instr    <= imem_instr;
                if_pc       <= pc;
                if_pc_plus4 <= pc_plus4;
                if_valid    <= 1'b1;
                if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
                pc <= is_j ? {pc_plus4[31:28], imem_instr[25:0], 2'b00} : pc_plus4;
            end
        end else begin
            if_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a scoreboard queue of expected issued
// instructions, popped by a monitor whenever the DUT presents a new word.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid, halt_req;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_instr, if_instr, if_pc, if_pc_plus4, fetch_count;
    logic        if_valid, halted, misalign_err;
    logic [31:0] imem_addr1, imem_instr1, if_instr1, if_pc1, if_pc_plus41, fetch_count1;
    logic        if_valid1, halted1, misalign_err1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
    } exp_t;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last = 32'd0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'd36) ? 32'h0C00000D : (32'h2001_0000 | {16'h0, a[15:0]});
    endfunction

    assign imem_instr  = mem(imem_addr);
    assign imem_instr1 = mem(imem_addr1);

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .halted(halted), .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    instruction_fetch #(.PREDECODE_J(0)) dut_nopd (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr1), .imem_instr(imem_instr1),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .if_valid(if_valid1), .if_instr(if_instr1), .if_pc(if_pc1),
        .if_pc_plus4(if_pc_plus41), .halted(halted1), .misalign_err(misalign_err1),
        .fetch_count(fetch_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4);
        q.push_back('{pc: pc, ins: ins, p4: p4});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_valid && fetch_count != last) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue got pc %h expected none", if_pc);
                end else begin
                    e = q.pop_front();
                    chk("sb_if_pc", if_pc, e.pc);
                    chk("sb_if_instr", if_instr, e.ins);
                    chk("sb_if_pc_plus4", if_pc_plus4, e.p4);
                end
            end
            last = fetch_count;
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0;
        #2;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fc", fetch_count, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        chk("boot_addr", imem_addr, 32'd0);
        for (int a = 0; a <= 36; a += 4) begin
            push(a, mem(a), a + 4);
            tick();
            if (a == 4) chk("fc_after_two", fetch_count, 32'd2);
        end
        chk("jal_target", imem_addr, 32'd52);
        chk("jal_nopredecode", imem_addr1, 32'd40);
        chk("jal_link", if_pc_plus4, 32'd40);
        push(32'd52, mem(32'd52), 32'd56);
        tick();
        chk("jal_no_bubble_fc", fetch_count, 32'd11);
        stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_addr", imem_addr, 32'd56);
            chk("stall_fc", fetch_count, 32'd11);
            chk("stall_if_pc", if_pc, 32'd52);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd92;
        tick();
        chk("stall_redir_addr", imem_addr, 32'd92);
        chk("stall_redir_valid", {31'd0, if_valid}, 32'd0);
        chk("stall_redir_addr_nopd", imem_addr1, 32'd92);
        stall = 1'b0; redirect_valid = 1'b0;
        push(32'd92, mem(32'd92), 32'd96);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_005E;
        tick();
        chk("misalign_addr", imem_addr, 32'h5C);
        chk("misalign_flag", {31'd0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        push(32'h5C, mem(32'h5C), 32'h60);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'd48;
        tick();
        chk("halt_setup_addr", imem_addr, 32'd48);
        redirect_valid = 1'b0; halt_req = 1'b1;
        tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'd48);
        halt_req = 1'b0;
        repeat (3) tick();
        chk("halted_stays", {31'd0, halted}, 32'd1);
        chk("halted_addr", imem_addr, 32'd48);
        chk("halted_valid", {31'd0, if_valid}, 32'd0);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        chk("halted_fc", fetch_count, 32'd13);
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", imem_addr, 32'd0);
        chk("async_rst_halted", {31'd0, halted}, 32'd0);
        chk("async_rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("async_rst_fc", fetch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reboot_valid", {31'd0, if_valid}, 32'd0);
        push(32'd0, mem(32'd0), 32'd4);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_setup_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        push(32'hFFFF_FFFC, 32'h2001_FFFC, 32'd0);
        tick();
        chk("wrap_addr", imem_addr, 32'd0);
        chk("wrap_pc_plus4", if_pc_plus4, 32'd0);
        push(32'd0, mem(32'd0), 32'd4);
        tick();
        stall = 1'b1;
        tick();
        tick();
        chk("sb_drained", q.size(), 32'd0);
        chk("final_fc", fetch_count, 32'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
